// File: rtl/reg_file_alu_pkg.sv
// Shared widths, opcode encodings, flag bit positions and the ALU result bundle
// used by the register-file/ALU datapath.
package reg_file_alu_pkg;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int NREG  = 1 << AW;
  localparam int NFLAG = 5;

  localparam int FL_C = 4;
  localparam int FL_L = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ADDU = 5'b00001;
  localparam logic [4:0] OP_ADDC = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_SUBC = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_XOR  = 5'b01000;
  localparam logic [4:0] OP_NOT  = 5'b01001;
  localparam logic [4:0] OP_LSH  = 5'b01010;
  localparam logic [4:0] OP_ASHU = 5'b01011;
  localparam logic [4:0] OP_MOV  = 5'b01100;
  localparam logic [4:0] OP_LUI  = 5'b01101;

  typedef struct packed {
    logic [DW-1:0]    result;
    logic             wr;
    logic [NFLAG-1:0] flags;
  } alu_res_t;
endpackage

// File: rtl/reg_file_alu_alu.sv
// Combinational ALU: result, register-write qualifier and next flag vector.
// Flags not touched by an opcode are passed through from the current value.
module alu
  import reg_file_alu_pkg::*;
(
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [4:0]       opcode,
  input  logic [NFLAG-1:0] flags,
  output alu_res_t         res
);
  logic          cin;
  logic [DW:0]   sum, dif;
  logic [3:0]    shamt;
  logic [DW-1:0] shl, shr_l, shr_a;
  logic          add_ovf, sub_ovf, upd_z;

  assign cin     = flags[FL_C];
  assign sum     = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, (opcode == OP_ADDC) & cin};
  assign dif     = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, (opcode == OP_SUBC) & cin};
  assign add_ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
  assign sub_ovf = (a[DW-1] != b[DW-1]) && (dif[DW-1] != a[DW-1]);
  assign shamt   = b[3:0];
  assign shl     = a << shamt;
  assign shr_l   = a >> shamt;
  assign shr_a   = $signed(a) >>> shamt;

  always_comb begin
    res        = '0;
    res.flags  = flags;
    upd_z      = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        res.result      = sum[DW-1:0];
        res.wr          = 1'b1;
        res.flags[FL_C] = sum[DW];
        res.flags[FL_F] = add_ovf;
        upd_z           = 1'b1;
      end
      OP_ADDU: begin
        res.result      = sum[DW-1:0];
        res.wr          = 1'b1;
        res.flags[FL_C] = sum[DW];
      end
      // CMP shares the subtractor and flag update but never writes back
      OP_SUB, OP_SUBC, OP_CMP: begin
        res.result      = dif[DW-1:0];
        res.wr          = (opcode != OP_CMP);
        res.flags[FL_C] = dif[DW];
        res.flags[FL_L] = a < b;
        res.flags[FL_F] = sub_ovf;
        res.flags[FL_N] = $signed(a) < $signed(b);
        upd_z           = 1'b1;
      end
      OP_AND:  begin res.result = a & b; res.wr = 1'b1; upd_z = 1'b1; end
      OP_OR:   begin res.result = a | b; res.wr = 1'b1; upd_z = 1'b1; end
      OP_XOR:  begin res.result = a ^ b; res.wr = 1'b1; upd_z = 1'b1; end
      OP_NOT:  begin res.result = ~b;    res.wr = 1'b1; upd_z = 1'b1; end
      OP_LSH:  begin res.result = b[4] ? shr_l : shl; res.wr = 1'b1; upd_z = 1'b1; end
      OP_ASHU: begin res.result = b[4] ? shr_a : shl; res.wr = 1'b1; upd_z = 1'b1; end
      OP_MOV:  begin res.result = b;     res.wr = 1'b1; upd_z = 1'b1; end
      OP_LUI:  begin res.result = {b[7:0], 8'h00}; res.wr = 1'b1; upd_z = 1'b1; end
      default: ;
    endcase
    if (upd_z) res.flags[FL_Z] = (res.result == '0);
  end
endmodule

// File: rtl/reg_file_alu.sv
// 16x16 register file with two async read ports, one sync write port,
// an immediate/register operand mux and the registered flag set.
module reg_file_alu
  import reg_file_alu_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [AW-1:0]    RdestRegLoc,
  input  logic [AW-1:0]    RsrcRegLoc,
  input  logic [DW-1:0]    Imm,
  input  logic             Imm_s,
  input  logic [4:0]       OpCode,
  output logic [DW-1:0]    AluOutput,
  output logic [DW-1:0]    RdestOut,
  output logic [NFLAG-1:0] Flags
);
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] opb;
  alu_res_t      res;

  assign RdestOut  = regs[RdestRegLoc];
  assign opb       = Imm_s ? Imm : regs[RsrcRegLoc];
  assign AluOutput = res.result;

  alu u_alu (
    .a      (RdestOut),
    .b      (opb),
    .opcode (OpCode),
    .flags  (Flags),
    .res    (res)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (En && res.wr) begin
      regs[RdestRegLoc] <= res.result;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)     Flags <= '0;
    else if (En) Flags <= res.flags;
  end
endmodule

// File: tb/tb_reg_file_alu.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the live outputs.
module tb_reg_file_alu;
  import reg_file_alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, En, Imm_s;
  logic [3:0]  RdestRegLoc, RsrcRegLoc;
  logic [15:0] Imm;
  logic [4:0]  OpCode;
  logic [15:0] AluOutput, RdestOut;
  logic [4:0]  Flags;

  typedef struct {
    string       name;
    int          sel;   // 0 RdestOut, 1 AluOutput, 2 Flags
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  reg_file_alu dut (
    .Clk(Clk), .Rst(Rst), .En(En), .RdestRegLoc(RdestRegLoc),
    .RsrcRegLoc(RsrcRegLoc), .Imm(Imm), .Imm_s(Imm_s), .OpCode(OpCode),
    .AluOutput(AluOutput), .RdestOut(RdestOut), .Flags(Flags)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = RdestOut;
        1:       act = AluOutput;
        default: act = {11'b0, Flags};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input logic [15:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] imm,
                       input logic en);
    OpCode = op; RdestRegLoc = rd; Imm = imm; Imm_s = 1'b1; En = en;
  endtask

  // one enabled edge with an immediate operand, then disable writes
  task automatic exec(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] imm);
    drive(op, rd, imm, 1'b1);
    step();
    En = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; En = 1'b1; Imm_s = 1'b1; Imm = 16'd5; OpCode = OP_ADD;
    RdestRegLoc = 4'd0; RsrcRegLoc = 4'd0;
    step(); step();
    En = 1'b0; Rst = 1'b0;
    expect_v("reset_flags", 2, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      RdestRegLoc = 4'(i);
      expect_v($sformatf("reset_r%0d", i), 0, 16'h0000);
      step();
    end

    drive(OP_ADD, 4'd0, 16'd5, 1'b1);
    expect_v("add_pre_alu", 1, 16'd5);
    step(); En = 1'b0;
    expect_v("add_r0", 0, 16'd5);
    expect_v("add_alu_after", 1, 16'd10);
    expect_v("add_flags", 2, 16'h0000);
    step();

    exec(OP_MOV, 4'd1, 16'hFFFF);
    drive(OP_ADD, 4'd1, 16'd1, 1'b1);
    expect_v("wrap_alu", 1, 16'h0000);
    step(); En = 1'b0;
    expect_v("wrap_r1", 0, 16'h0000);
    expect_v("wrap_flags", 2, 16'b10010);
    step();

    exec(OP_MOV, 4'd2, 16'd3);
    drive(OP_CMP, 4'd2, 16'd5, 1'b1);
    expect_v("cmp_alu", 1, 16'hFFFE);
    step(); En = 1'b0;
    expect_v("cmp_r2", 0, 16'd3);
    expect_v("cmp_flags", 2, 16'b11001);
    step();

    exec(OP_MOV, 4'd3, 16'h8000);
    exec(OP_ASHU, 4'd3, 16'h0011);
    expect_v("ashu_r3", 0, 16'hC000);
    expect_v("ashu_flags", 2, 16'b11001);
    step();
    exec(OP_MOV, 4'd3, 16'h8000);
    exec(OP_LSH, 4'd3, 16'h0011);
    expect_v("lsh_r3", 0, 16'h4000);
    step();

    exec(OP_MOV, 4'd4, 16'h8000);
    exec(OP_SUB, 4'd4, 16'd1);
    expect_v("sub_ovf_r4", 0, 16'h7FFF);
    expect_v("sub_ovf_flags", 2, 16'b00101);
    step();

    exec(OP_MOV, 4'd5, 16'hFFFF);
    exec(OP_ADD, 4'd5, 16'd2);
    expect_v("carry_flags", 2, 16'b10001);
    step();
    exec(OP_ADDC, 4'd5, 16'd3);
    expect_v("addc_r5", 0, 16'd5);
    expect_v("addc_flags", 2, 16'b00001);
    step();

    drive(OP_OR, 4'd5, 16'h0000, 1'b0);
    Imm_s = 1'b0; RsrcRegLoc = 4'd3;
    expect_v("or_reg_alu", 1, 16'h4005);
    step();
    OpCode = OP_XOR; RsrcRegLoc = 4'd4;
    expect_v("xor_reg_alu", 1, 16'h7FFA);
    step();

    drive(5'b11111, 4'd5, 16'd9, 1'b1);
    expect_v("undef_alu", 1, 16'h0000);
    step(); En = 1'b0;
    expect_v("undef_r5", 0, 16'd5);
    expect_v("undef_flags", 2, 16'b00001);
    step();

    drive(OP_ADD, 4'd5, 16'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      expect_v("en0_alu", 1, 16'd12);
      expect_v("en0_r5", 0, 16'd5);
      step();
    end

    drive(OP_MOV, 4'd6, 16'h1234, 1'b1);
    expect_v("nobypass_pre", 0, 16'h0000);
    step(); En = 1'b0;
    expect_v("nobypass_post", 0, 16'h1234);
    step();

    exec(OP_LUI, 4'd7, 16'h00AB);
    expect_v("lui_r7", 0, 16'hAB00);
    step();
    exec(OP_NOT, 4'd8, 16'h00FF);
    expect_v("not_r8", 0, 16'hFF00);
    expect_v("not_flags", 2, 16'b00001);
    step();

    exec(OP_SUBC, 4'd5, 16'd5);
    expect_v("subc_r5", 0, 16'h0000);
    expect_v("subc_flags", 2, 16'b00010);
    step();

    RdestRegLoc = 4'd7;
    Rst = 1'b1;
    expect_v("async_rst_r7", 0, 16'h0000);
    expect_v("async_rst_flags", 2, 16'h0000);
    step();
    Rst = 1'b0;

    for (int c = 0; c < 20 && q.size() > 0; c++) step();
    if (q.size() > 0) begin
      bad++; total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
